// File: rtl/regfile_writeback.sv
// Register file write-port arbiter: ALU results win the port, mul/div results queue in a squashable FIFO.
// Latency: ALU 1 cycle; mul/div at least 2 cycles (enqueue edge, then pop edge), plus one per ALU write.
// Backpressure: ALU never stalls; MdReady drops when the FIFO is full, with no same-cycle fall-through.
module regfile_writeback #(
  parameter int DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        AluWrite,
  input  logic [4:0]  AluDest,
  input  logic [31:0] AluData,
  input  logic        MdValid,
  input  logic [4:0]  MdDest,
  input  logic [31:0] MdData,
  output logic        MdReady,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  input  logic [4:0]  ReadRegister1,
  input  logic [4:0]  ReadRegister2,
  output logic        FwdHit1,
  output logic        FwdHit2,
  output logic [31:0] FwdData1,
  output logic [31:0] FwdData2,
  output logic        QueueEmpty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] q_vld;
  logic [4:0]       q_dest [DEPTH];
  logic [31:0]      q_dat  [DEPTH];

  logic alu_go;
  logic pop;
  logic enq;

  assign MdReady    = (count < FULL);
  assign QueueEmpty = (count == '0);
  assign alu_go     = AluWrite && (AluDest != 5'd0);
  // A squashed head drains even while the ALU owns the port; it never writes.
  assign pop        = (count != '0) && (!q_vld[rptr] || !alu_go);
  assign enq        = MdValid && MdReady && (MdDest != 5'd0);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      q_vld         <= '0;
      RegWrite      <= 1'b0;
      WriteRegister <= 5'd0;
      WriteData     <= 32'd0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (alu_go && (q_dest[i] == AluDest)) q_vld[i] <= 1'b0;
      end
      if (pop) begin
        q_vld[rptr] <= 1'b0;
        rptr        <= rptr + 1'b1;
      end
      // The ALU write is younger, so a same-cycle enqueue to its dest arrives already dead.
      if (enq) begin
        q_vld[wptr] <= !(alu_go && (MdDest == AluDest));
        wptr        <= wptr + 1'b1;
      end
      if (enq && !pop)      count <= count + 1'b1;
      else if (pop && !enq) count <= count - 1'b1;

      if (alu_go) begin
        RegWrite      <= 1'b1;
        WriteRegister <= AluDest;
        WriteData     <= AluData;
      end else if (pop && q_vld[rptr]) begin
        RegWrite      <= 1'b1;
        WriteRegister <= q_dest[rptr];
        WriteData     <= q_dat[rptr];
      end else begin
        RegWrite      <= 1'b0;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (enq) begin
      q_dest[wptr] <= MdDest;
      q_dat[wptr]  <= MdData;
    end
  end

  // Walk oldest to youngest so the youngest match overrides; the output stage is older than any queued entry.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    FwdHit1  = 1'b0;
    FwdHit2  = 1'b0;
    FwdData1 = 32'd0;
    FwdData2 = 32'd0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rptr + PW'(k);
      if ((CW'(k) < count) && q_vld[idx]) begin
        if ((ReadRegister1 != 5'd0) && (q_dest[idx] == ReadRegister1)) begin
          FwdHit1  = 1'b1;
          FwdData1 = q_dat[idx];
        end
        if ((ReadRegister2 != 5'd0) && (q_dest[idx] == ReadRegister2)) begin
          FwdHit2  = 1'b1;
          FwdData2 = q_dat[idx];
        end
      end
    end
    if (!FwdHit1 && RegWrite && (ReadRegister1 != 5'd0) && (WriteRegister == ReadRegister1)) begin
      FwdHit1  = 1'b1;
      FwdData1 = WriteData;
    end
    if (!FwdHit2 && RegWrite && (ReadRegister2 != 5'd0) && (WriteRegister == ReadRegister2)) begin
      FwdHit2  = 1'b1;
      FwdData2 = WriteData;
    end
  end

endmodule
